// File: rtl/tb_multi_hart_status_monitor.sv
// ---------------------------------------------------------------------------
// tb_multi_hart_status_monitor
//
// Run controller for multi-hart / multi-core benches and FPGA prototypes.
// It gathers per-channel passed/failed/exit handshakes, runs a global cycle
// watchdog and a per-channel hang detector, and produces one registered
// verdict that stays stable until the next start or reset.
//
// Ports
//   clk_i              bench clock
//   rst_i              asynchronous reset, active-high
//   start_i            1-cycle pulse: begin a run (accepted in IDLE and DONE)
//   max_cycles_i       watchdog limit, 0 disables it; sampled at start
//   hang_limit_i       per-channel idle limit, 0 disables it; sampled at start
//   chan_passed_i      per-channel tests_passed
//   chan_failed_i      per-channel tests_failed
//   chan_exit_valid_i  per-channel exit strobe
//   chan_exit_value_i  exit values, channel k at [32k+31:32k]
//   chan_retire_i      per-channel instruction-retired heartbeat
//   done_o             verdict valid
//   verdict_o          0 NONE 1 PASS 2 FAIL 3 EXIT_FAIL 4 TIMEOUT 5 HANG
//   fail_chan_o        channel responsible for FAIL/EXIT_FAIL/HANG, else 0
//   exit_value_o       exit value of fail_chan_o on EXIT_FAIL, else 0
//   finished_mask_o    channels that completed cleanly (sticky within a run)
//   cycle_cnt_o        RUN cycles elapsed, frozen once the verdict is out
// ---------------------------------------------------------------------------
module tb_multi_hart_status_monitor #(
  parameter int  NUM_CH = 2,
  parameter int  CNT_W  = 32,
  parameter int  HANG_W = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     max_cycles_i,
  input  logic [HANG_W-1:0]    hang_limit_i,
  input  logic [NUM_CH-1:0]    chan_passed_i,
  input  logic [NUM_CH-1:0]    chan_failed_i,
  input  logic [NUM_CH-1:0]    chan_exit_valid_i,
  input  logic [NUM_CH*32-1:0] chan_exit_value_i,
  input  logic [NUM_CH-1:0]    chan_retire_i,
  output logic                 done_o,
  output logic [2:0]           verdict_o,
  output logic [CH_W-1:0]      fail_chan_o,
  output logic [31:0]          exit_value_o,
  output logic [NUM_CH-1:0]    finished_mask_o,
  output logic [CNT_W-1:0]     cycle_cnt_o
);

  localparam logic [2:0] V_NONE      = 3'd0;
  localparam logic [2:0] V_PASS      = 3'd1;
  localparam logic [2:0] V_FAIL      = 3'd2;
  localparam logic [2:0] V_EXIT_FAIL = 3'd3;
  localparam logic [2:0] V_TIMEOUT   = 3'd4;
  localparam logic [2:0] V_HANG      = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Registered state
  state_t                         r_state;
  logic                           r_done;
  logic [2:0]                     r_verdict;
  logic [CH_W-1:0]                r_fail_chan;
  logic [31:0]                    r_exit_value;
  logic [NUM_CH-1:0]              r_mask;
  logic [CNT_W-1:0]               r_cycle;
  logic [CNT_W-1:0]               r_max;
  logic [HANG_W-1:0]              r_hang_lim;
  logic [NUM_CH-1:0][HANG_W-1:0]  r_idle;

  // Next-state values
  state_t                         w_state_next;
  logic                           w_done_next;
  logic [2:0]                     w_verdict_next;
  logic [CH_W-1:0]                w_fail_chan_next;
  logic [31:0]                    w_exit_value_next;
  logic [NUM_CH-1:0]              w_mask_next;
  logic [CNT_W-1:0]               w_cycle_next;
  logic [CNT_W-1:0]               w_max_next;
  logic [HANG_W-1:0]              w_hang_lim_next;
  logic [NUM_CH-1:0][HANG_W-1:0]  w_idle_next;
  logic [NUM_CH-1:0][HANG_W-1:0]  w_idle_upd;

  // Per-channel decode
  logic [NUM_CH-1:0]              w_exit_nz;
  logic [NUM_CH-1:0]              w_fin_now;
  logic [NUM_CH-1:0]              w_hang;
  logic                           w_timeout;
  logic                           w_all_fin;
  logic [CH_W-1:0]                w_fail_idx;
  logic [CH_W-1:0]                w_exit_idx;
  logic [31:0]                    w_exit_val;
  logic [CH_W-1:0]                w_hang_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [31:0] w_val;
      assign w_val         = chan_exit_value_i[32*gi +: 32];
      assign w_exit_nz[gi] = chan_exit_valid_i[gi] && (w_val != 32'd0);
      // A failure on the same cycle overrides any clean completion.
      assign w_fin_now[gi] = (chan_passed_i[gi] ||
                              (chan_exit_valid_i[gi] && (w_val == 32'd0))) &&
                             !chan_failed_i[gi];
      // Channels finished earlier or finishing now cannot hang.
      assign w_hang[gi]    = (r_hang_lim != '0) &&
                             (r_idle[gi] >= r_hang_lim) &&
                             !(r_mask[gi] || w_fin_now[gi]);
    end
  endgenerate

  assign w_timeout = (r_max != '0) && (r_cycle >= r_max);
  assign w_all_fin = &(r_mask | w_fin_now);

  // Lowest-index winners: scan downwards so the lowest match is assigned last.
  always_comb begin
    w_fail_idx = '0;
    w_exit_idx = '0;
    w_exit_val = '0;
    w_hang_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (chan_failed_i[k]) begin
        w_fail_idx = CH_W'(k);
      end
      if (w_exit_nz[k]) begin
        w_exit_idx = CH_W'(k);
        w_exit_val = chan_exit_value_i[32*k +: 32];
      end
      if (w_hang[k]) begin
        w_hang_idx = CH_W'(k);
      end
    end
  end

  // Idle counters: frozen once the channel is finished, cleared by a retire,
  // otherwise saturating increment.
  always_comb begin
    w_idle_upd = r_idle;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!r_mask[k]) begin
        if (chan_retire_i[k]) begin
          w_idle_upd[k] = '0;
        end else if (r_idle[k] != {HANG_W{1'b1}}) begin
          w_idle_upd[k] = r_idle[k] + 1'b1;
        end
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_next      = r_state;
    w_done_next       = r_done;
    w_verdict_next    = r_verdict;
    w_fail_chan_next  = r_fail_chan;
    w_exit_value_next = r_exit_value;
    w_mask_next       = r_mask;
    w_cycle_next      = r_cycle;
    w_max_next        = r_max;
    w_hang_lim_next   = r_hang_lim;
    w_idle_next       = r_idle;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_state_next      = S_RUN;
          w_done_next       = 1'b0;
          w_verdict_next    = V_NONE;
          w_fail_chan_next  = '0;
          w_exit_value_next = '0;
          w_mask_next       = '0;
          w_cycle_next      = '0;
          w_max_next        = max_cycles_i;
          w_hang_lim_next   = hang_limit_i;
          w_idle_next       = '0;
        end
      end

      S_RUN: begin
        if (r_cycle != {CNT_W{1'b1}}) begin
          w_cycle_next = r_cycle + 1'b1;
        end
        w_mask_next = r_mask | w_fin_now;
        w_idle_next = w_idle_upd;

        if (|chan_failed_i) begin
          w_state_next     = S_DONE;
          w_done_next      = 1'b1;
          w_verdict_next   = V_FAIL;
          w_fail_chan_next = w_fail_idx;
        end else if (|w_exit_nz) begin
          w_state_next      = S_DONE;
          w_done_next       = 1'b1;
          w_verdict_next    = V_EXIT_FAIL;
          w_fail_chan_next  = w_exit_idx;
          w_exit_value_next = w_exit_val;
        end else if (|w_hang) begin
          w_state_next     = S_DONE;
          w_done_next      = 1'b1;
          w_verdict_next   = V_HANG;
          w_fail_chan_next = w_hang_idx;
        end else if (w_timeout) begin
          w_state_next   = S_DONE;
          w_done_next    = 1'b1;
          w_verdict_next = V_TIMEOUT;
        end else if (w_all_fin) begin
          w_state_next   = S_DONE;
          w_done_next    = 1'b1;
          w_verdict_next = V_PASS;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_verdict    <= V_NONE;
      r_fail_chan  <= '0;
      r_exit_value <= '0;
      r_mask       <= '0;
      r_cycle      <= '0;
      r_max        <= '0;
      r_hang_lim   <= '0;
      r_idle       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_done       <= w_done_next;
      r_verdict    <= w_verdict_next;
      r_fail_chan  <= w_fail_chan_next;
      r_exit_value <= w_exit_value_next;
      r_mask       <= w_mask_next;
      r_cycle      <= w_cycle_next;
      r_max        <= w_max_next;
      r_hang_lim   <= w_hang_lim_next;
      r_idle       <= w_idle_next;
    end
  end

  assign done_o          = r_done;
  assign verdict_o       = r_verdict;
  assign fail_chan_o     = r_fail_chan;
  assign exit_value_o    = r_exit_value;
  assign finished_mask_o = r_mask;
  assign cycle_cnt_o     = r_cycle;

endmodule

// File: tb/tb_tb_multi_hart_status_monitor.sv
// ---------------------------------------------------------------------------
// Bench for tb_multi_hart_status_monitor (2 channels).
// Each run is a per-cycle stimulus table; a reference model walks the table
// using the verdict rules and queues the expected result. A monitor pops the
// queue when done_o rises and checks that the verdict is held afterwards.
// ---------------------------------------------------------------------------
module tb_tb_multi_hart_status_monitor;

  localparam int NCH    = 2;
  localparam int CNT_W  = 32;
  localparam int HANG_W = 16;
  localparam int LMAX   = 40;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [CNT_W-1:0]     max_cycles = '0;
  logic [HANG_W-1:0]    hang_limit = '0;
  logic [NCH-1:0]       passed = '0;
  logic [NCH-1:0]       failed = '0;
  logic [NCH-1:0]       exit_valid = '0;
  logic [NCH*32-1:0]    exit_bus = '0;
  logic [NCH-1:0]       retire = '0;
  logic                 done_o;
  logic [2:0]           verdict_o;
  logic [0:0]           fail_chan_o;
  logic [31:0]          exit_value_o;
  logic [NCH-1:0]       mask_o;
  logic [CNT_W-1:0]     cycle_o;

  tb_multi_hart_status_monitor #(
    .NUM_CH (NCH),
    .CNT_W  (CNT_W),
    .HANG_W (HANG_W)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .max_cycles_i      (max_cycles),
    .hang_limit_i      (hang_limit),
    .chan_passed_i     (passed),
    .chan_failed_i     (failed),
    .chan_exit_valid_i (exit_valid),
    .chan_exit_value_i (exit_bus),
    .chan_retire_i     (retire),
    .done_o            (done_o),
    .verdict_o         (verdict_o),
    .fail_chan_o       (fail_chan_o),
    .exit_value_o      (exit_value_o),
    .finished_mask_o   (mask_o),
    .cycle_cnt_o       (cycle_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]     verdict;
    logic [0:0]     chan;
    logic [31:0]    val;
    logic [NCH-1:0] mask;
    logic [31:0]    cyc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Stimulus table for one run
  logic [NCH-1:0] s_pass [LMAX];
  logic [NCH-1:0] s_fail [LMAX];
  logic [NCH-1:0] s_ev   [LMAX];
  logic [NCH-1:0] s_ret  [LMAX];
  logic [31:0]    s_val  [LMAX][NCH];
  logic [31:0]    s_max;
  logic [15:0]    s_hang;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: first cycle at which any verdict rule fires.
  function automatic bit model(output exp_t e);
    logic [NCH-1:0] fin_set;
    int             last_ret [NCH];
    fin_set = '0;
    e = '0;
    for (int k = 0; k < NCH; k++) last_ret[k] = -1;
    for (int c = 0; c < LMAX; c++) begin
      logic [NCH-1:0] fin_now;
      int ff, fe, fh, idle_k;
      bit decided;
      fin_now = '0;
      ff = -1; fe = -1; fh = -1;
      for (int k = NCH - 1; k >= 0; k--) begin
        if ((s_pass[c][k] || (s_ev[c][k] && s_val[c][k] == 0)) && !s_fail[c][k]) fin_now[k] = 1'b1;
      end
      for (int k = NCH - 1; k >= 0; k--) begin
        idle_k = (last_ret[k] < 0) ? c : (c - 1 - last_ret[k]);
        if (s_fail[c][k]) ff = k;
        if (s_ev[c][k] && s_val[c][k] != 0) fe = k;
        if (s_hang != 0 && !fin_set[k] && !fin_now[k] && idle_k >= int'(s_hang)) fh = k;
      end
      decided = 1'b1;
      if (ff >= 0) begin
        e.verdict = 3'd2; e.chan = 1'(ff);
      end else if (fe >= 0) begin
        e.verdict = 3'd3; e.chan = 1'(fe); e.val = s_val[c][fe];
      end else if (fh >= 0) begin
        e.verdict = 3'd5; e.chan = 1'(fh);
      end else if (s_max != 0 && c >= int'(s_max)) begin
        e.verdict = 3'd4;
      end else if ((fin_set | fin_now) == {NCH{1'b1}}) begin
        e.verdict = 3'd1;
      end else begin
        decided = 1'b0;
      end
      if (decided) begin
        e.mask = fin_set | fin_now;
        e.cyc  = 32'(c + 1);
        return 1'b1;
      end
      fin_set = fin_set | fin_now;
      for (int k = 0; k < NCH; k++) if (s_ret[c][k]) last_ret[k] = c;
    end
    return 1'b0;
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < LMAX; c++) begin
      s_pass[c] = '0; s_fail[c] = '0; s_ev[c] = '0; s_ret[c] = '0;
      for (int k = 0; k < NCH; k++) s_val[c][k] = '0;
    end
    s_max  = '0;
    s_hang = '0;
  endtask

  task automatic rand_stim();
    int stop [NCH];
    clear_stim();
    s_max  = 32'($urandom_range(38, 5));
    s_hang = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(15, 3)) : 16'd0;
    for (int k = 0; k < NCH; k++) stop[k] = int'($urandom_range(LMAX, 0));
    for (int c = 0; c < LMAX; c++) begin
      for (int k = 0; k < NCH; k++) begin
        s_pass[c][k] = ($urandom_range(24, 0) == 0);
        s_fail[c][k] = ($urandom_range(70, 0) == 0);
        s_ev[c][k]   = ($urandom_range(30, 0) == 0);
        s_val[c][k]  = ($urandom_range(1, 0) == 1) ? 32'($urandom_range(200, 1)) : 32'd0;
        s_ret[c][k]  = (c < stop[k]) && ($urandom_range(3, 0) != 0);
      end
    end
  endtask

  task automatic drive(input int c);
    passed     = s_pass[c];
    failed     = s_fail[c];
    exit_valid = s_ev[c];
    retire     = s_ret[c];
    for (int k = 0; k < NCH; k++) exit_bus[32*k +: 32] = s_val[c][k];
  endtask

  task automatic idle_inputs();
    passed = '0; failed = '0; exit_valid = '0; retire = '0; exit_bus = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"},    64'(done_o),       64'(0));
    check({tag, "_verdict"}, 64'(verdict_o),    64'(0));
    check({tag, "_chan"},    64'(fail_chan_o),  64'(0));
    check({tag, "_exitval"}, 64'(exit_value_o), 64'(0));
    check({tag, "_mask"},    64'(mask_o),       64'(0));
    check({tag, "_cycle"},   64'(cycle_o),      64'(0));
  endtask

  // One run: abort_at < 0 runs to completion, otherwise reset at that cycle.
  task automatic run_one(input int abort_at);
    exp_t e;
    bit   ok;
    bit   was_done;
    ok = model(e);
    if (abort_at < 0) begin
      if (ok) sb_q.push_back(e);
      else begin
        errors++; checks++;
        $display("FAIL model_no_verdict: got none, required a verdict within %0d cycles", LMAX);
      end
    end
    @(negedge clk);
    was_done   = done_o;
    max_cycles = s_max;
    hang_limit = s_hang;
    idle_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (was_done) begin
      check("restart_done",    64'(done_o),    64'(0));
      check("restart_verdict", 64'(verdict_o), 64'(0));
      check("restart_mask",    64'(mask_o),    64'(0));
      check("restart_cycle",   64'(cycle_o),   64'(0));
    end
    for (int c = 0; c < LMAX; c++) begin
      if (c == abort_at) break;
      drive(c);
      @(negedge clk);
    end
    idle_inputs();
    if (abort_at >= 0) begin
      check("abort_cycle", 64'(cycle_o), 64'(abort_at));
      #2 rst = 1'b1;
      #1 check_zero("abort");
      @(negedge clk);
      rst = 1'b0;
    end else begin
      for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
      check("sb_drain", 64'(sb_q.size()), 64'(0));
      sb_q.delete();
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    exp_t cur;
    bit   have;
    logic prev;
    have = 1'b0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        have = 1'b0;
      end else begin
        if (done_o && !prev) begin
          if (sb_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL sb_unexpected_done: got verdict=%0d, required no verdict", verdict_o);
            have = 1'b0;
          end else begin
            cur  = sb_q.pop_front();
            have = 1'b1;
            $display("verdict=%0d chan=%0d exit=%0d mask=%b cycles=%0d (expected %0d/%0d/%0d/%b/%0d)",
                     verdict_o, fail_chan_o, exit_value_o, mask_o, cycle_o,
                     cur.verdict, cur.chan, cur.val, cur.mask, cur.cyc);
            check("verdict",   64'(verdict_o),    64'(cur.verdict));
            check("fail_chan", 64'(fail_chan_o),  64'(cur.chan));
            check("exit_val",  64'(exit_value_o), 64'(cur.val));
            check("mask",      64'(mask_o),       64'(cur.mask));
            check("cycle_cnt", 64'(cycle_o),      64'(cur.cyc));
          end
        end else if (done_o && have) begin
          check("hold_verdict", 64'(verdict_o), 64'(cur.verdict));
          check("hold_cycle",   64'(cycle_o),   64'(cur.cyc));
          check("hold_mask",    64'(mask_o),    64'(cur.mask));
        end
        prev = done_o;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    clear_stim();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Inputs ignored in IDLE
    for (int i = 0; i < 5; i++) begin
      passed = 2'b11; failed = 2'b01; exit_valid = 2'b10;
      exit_bus = {32'd5, 32'd0}; retire = 2'b11;
      @(negedge clk);
    end
    idle_inputs();
    check_zero("idle");

    // T1: ch0 passes at c5, ch1 exits 0 at c9
    clear_stim();
    s_pass[5][0] = 1'b1; s_ev[9][1] = 1'b1;
    run_one(-1);

    // T2: ch1 fails while ch0 exits 7 on the same cycle
    clear_stim();
    s_fail[3][1] = 1'b1; s_ev[3][0] = 1'b1; s_val[3][0] = 32'd7;
    run_one(-1);

    // T3: both channels exit nonzero on the same cycle
    clear_stim();
    s_ev[4] = 2'b11; s_val[4][0] = 32'd3; s_val[4][1] = 32'd9;
    run_one(-1);

    // T4: watchdog at 20 with constant heartbeat
    clear_stim();
    s_max = 32'd20;
    for (int c = 0; c < LMAX; c++) s_ret[c] = 2'b11;
    run_one(-1);

    // T5: ch0 finishes early, ch1 stops retiring after c4
    clear_stim();
    s_hang = 16'd8;
    s_pass[2][0] = 1'b1;
    for (int c = 0; c <= 4; c++) s_ret[c][1] = 1'b1;
    run_one(-1);

    // T6: reset mid-run, then a fresh run counts from 0
    clear_stim();
    for (int c = 0; c < LMAX; c++) s_ret[c] = 2'b11;
    run_one(6);
    clear_stim();
    s_pass[5][0] = 1'b1; s_ev[9][1] = 1'b1;
    run_one(-1);

    // Randomized runs, each restarted from DONE
    for (int r = 0; r < 30; r++) begin
      rand_stim();
      run_one(-1);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
